// File: rtl/spi_slave_frame_rx_pkg.sv
// Shared definitions for the SPI command-frame receiver: field widths,
// bit-counter sizing, command codes, FSM encoding and the frame layout.
package spi_slave_frame_rx_pkg;

  localparam int LEN_SPI      = 32;
  localparam int SPI_CODE_LEN = 6;
  localparam int SPI_ADDR_LEN = 10;
  localparam int SPI_DATA_LEN = 16;

  // The bit counter must hold LEN_SPI+1, which is its saturation value.
  localparam int CNT_W = $clog2(LEN_SPI + 2);
  localparam int IDX_W = $clog2(LEN_SPI);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(LEN_SPI);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(LEN_SPI + 1);

  // Command codes understood by the downstream decoder.
  localparam logic [SPI_CODE_LEN-1:0] CMD_DUMMY      = 6'd0;
  localparam logic [SPI_CODE_LEN-1:0] CMD_WR_REC     = 6'd4;
  localparam logic [SPI_CODE_LEN-1:0] CMD_AFE_RST    = 6'd7;
  localparam logic [SPI_CODE_LEN-1:0] CMD_AFE_RST_RM = 6'd8;
  localparam logic [SPI_CODE_LEN-1:0] CMD_RD_ADC     = 6'd19;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RX   = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Frame layout: code in the top bits, data in the bottom bits.
  typedef struct packed {
    logic [SPI_CODE_LEN-1:0] code;
    logic [SPI_ADDR_LEN-1:0] addr;
    logic [SPI_DATA_LEN-1:0] data;
  } cmd_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for one asynchronous pin, with rise/fall pulses
// produced by comparing the last stage against a one-cycle delayed copy.
module spi_sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // Shift the pin through the synchroniser chain and keep a delayed copy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the value from
      // before this edge; blocking here would collapse the chain to one flop.
      sync_q <= {sync_q[STAGES-2:0], din};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/spi_slave_frame_rx.sv
// SPI slave front end: oversamples sck/cs_n/mosi in the system clock domain,
// assembles LSB-first 32-bit command frames, strobes them to the decoder and
// shifts the captured response word out on miso during the same frame.
module spi_slave_frame_rx
  import spi_slave_frame_rx_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                    clk_50M,
  input  logic                    rst,
  input  logic                    sck,
  input  logic                    cs_n,
  input  logic                    mosi,
  output logic                    miso,
  input  logic [LEN_SPI-1:0]      rsp_data,
  output logic                    cmd_valid,
  output logic [SPI_CODE_LEN-1:0] cmd_code,
  output logic [SPI_ADDR_LEN-1:0] cmd_addr,
  output logic [SPI_DATA_LEN-1:0] cmd_data,
  output logic                    frame_err,
  output logic                    busy
);

  logic sck_rise, sck_level_unused, sck_fall_unused;
  logic cs_level, cs_rise, cs_fall;
  logic mosi_level, mosi_rise_unused, mosi_fall_unused;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_sck (
    .clk(clk_50M), .rst(rst), .din(sck),
    .level(sck_level_unused), .rise(sck_rise), .fall(sck_fall_unused)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .clk(clk_50M), .rst(rst), .din(cs_n),
    .level(cs_level), .rise(cs_rise), .fall(cs_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk(clk_50M), .rst(rst), .din(mosi),
    .level(mosi_level), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
  );

  state_t             state;
  logic [CNT_W-1:0]   bit_cnt;
  logic [CNT_W-1:0]   next_cnt;
  logic [LEN_SPI-1:0] shift_rx;
  logic [LEN_SPI-1:0] shift_tx;
  cmd_t               cmd_q;
  logic [SYNC_STAGES:0] prime;
  logic               armed;

  assign next_cnt = bit_cnt + CNT_W'(1);

  // Arm frame reception only once the synchronised cs_n has been seen high
  // after reset, so a frame already in flight at reset release is ignored.
  always_ff @(posedge clk_50M or posedge rst) begin
    if (rst) begin
      prime <= '0;
      armed <= 1'b0;
    end else begin
      prime <= {prime[SYNC_STAGES-1:0], 1'b1};
      armed <= armed | (prime[SYNC_STAGES] & cs_level);
    end
  end

  // Frame FSM: capture response on cs_n fall, shift bits on sck rise,
  // validate the bit count on cs_n rise and strobe the result for one cycle.
  always_ff @(posedge clk_50M or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      shift_rx  <= '0;
      shift_tx  <= '0;
      miso      <= 1'b0;
      cmd_valid <= 1'b0;
      frame_err <= 1'b0;
      cmd_q     <= '0;
    end else begin
      // Strobes are single-cycle: cleared every cycle unless DONE sets them.
      cmd_valid <= 1'b0;
      frame_err <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          miso <= 1'b0;
          if (armed && cs_fall) begin
            bit_cnt  <= '0;
            shift_tx <= rsp_data;
            miso     <= rsp_data[0];
            state    <= ST_RX;
          end
        end
        ST_RX: begin
          if (sck_rise) begin
            if (bit_cnt < CNT_FULL) shift_rx[bit_cnt[IDX_W-1:0]] <= mosi_level;
            if (bit_cnt != CNT_SAT) bit_cnt <= next_cnt;
            miso <= (next_cnt < CNT_FULL) ? shift_tx[next_cnt[IDX_W-1:0]] : 1'b0;
          end
          // A coincident sck rise has already been sampled above; the frame
          // closes with the updated count.
          if (cs_rise) begin
            miso  <= 1'b0;
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          miso <= 1'b0;
          if (bit_cnt == CNT_FULL) begin
            cmd_valid <= 1'b1;
            cmd_q     <= cmd_t'(shift_rx);
          end else begin
            frame_err <= 1'b1;
          end
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign cmd_code = cmd_q.code;
  assign cmd_addr = cmd_q.addr;
  assign cmd_data = cmd_q.data;
  assign busy     = ~cs_level;

endmodule

// File: tb/tb_spi_slave_frame_rx.sv
// Directed bench for spi_slave_frame_rx: drives LSB-first frames as an SPI
// master (sck idle high, 200-unit period) and checks decoded commands,
// error strobes, miso read-back and reset behaviour.
module tb_spi_slave_frame_rx;

  logic        clk_50M = 1'b0;
  logic        rst     = 1'b1;
  logic        sck     = 1'b1;
  logic        cs_n    = 1'b1;
  logic        mosi    = 1'b0;
  logic [31:0] rsp_data = '0;
  logic        miso, cmd_valid, frame_err, busy;
  logic [5:0]  cmd_code;
  logic [9:0]  cmd_addr;
  logic [15:0] cmd_data;

  int n_checks = 0;
  int n_fail   = 0;
  int valid_cnt = 0, err_cnt = 0, miso_hi_cnt = 0, busy_hi_cnt = 0;

  always #10 clk_50M = ~clk_50M;

  spi_slave_frame_rx dut (
    .clk_50M(clk_50M), .rst(rst), .sck(sck), .cs_n(cs_n), .mosi(mosi),
    .miso(miso), .rsp_data(rsp_data), .cmd_valid(cmd_valid),
    .cmd_code(cmd_code), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .frame_err(frame_err), .busy(busy)
  );

  // Count strobes and output activity, sampled away from the active edge.
  always @(negedge clk_50M) begin
    if (cmd_valid === 1'b1) valid_cnt++;
    if (frame_err === 1'b1) err_cnt++;
    if (miso === 1'b1)      miso_hi_cnt++;
    if (busy === 1'b1)      busy_hi_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // One master transaction of nbits sck pulses; rd collects miso sampled
  // on each sck falling edge, busy_mid is busy seen after cs_n settles.
  task automatic send_frame(input logic [31:0] word, input int nbits,
                            output logic [31:0] rd, output logic busy_mid);
    rd = '0;
    cs_n = 1'b0;
    #200;
    busy_mid = busy;
    rsp_data = rsp_data ^ 32'hFFFF_FFFF;  // later changes must not matter
    for (int i = 0; i < nbits; i++) begin
      sck = 1'b0;
      if (i < 32) rd[i] = miso;
      mosi = (i < 32) ? word[i] : 1'b0;
      #100;
      sck = 1'b1;
      #100;
    end
    cs_n = 1'b1;
    #300;
  endtask

  task automatic check_cmd(input string tag, input logic [5:0] c,
                           input logic [9:0] a, input logic [15:0] d);
    check({tag, "_code"}, 32'(cmd_code), 32'(c));
    check({tag, "_addr"}, 32'(cmd_addr), 32'(a));
    check({tag, "_data"}, 32'(cmd_data), 32'(d));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        bm;
    int          v0, e0, m0, b0;

    // Reset state
    #100;
    check("rst_miso",      32'(miso),      32'd0);
    check("rst_cmd_valid", 32'(cmd_valid), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check_cmd("rst", 6'd0, 10'd0, 16'd0);
    rst = 1'b0;
    #300;

    // 1: AFE reset-remove command
    v0 = valid_cnt; e0 = err_cnt;
    send_frame({6'd8, 10'd4, 16'h0}, 32, rd, bm);
    check("t1_busy_mid", 32'(bm), 32'd1);
    check("t1_valid_cnt", 32'(valid_cnt - v0), 32'd1);
    check("t1_err_cnt",   32'(err_cnt - e0),   32'd0);
    check_cmd("t1", 6'd8, 10'd4, 16'h0);
    check("t1_busy_after", 32'(busy), 32'd0);

    // 2: ADC read with response read-back
    rsp_data = 32'hA5A5_1234;
    v0 = valid_cnt;
    send_frame({6'd19, {8'd2, 2'd3}, 16'h0}, 32, rd, bm);
    check("t2_miso_word", rd, 32'hA5A5_1234);
    check("t2_valid_cnt", 32'(valid_cnt - v0), 32'd1);
    check_cmd("t2", 6'd19, 10'h00B, 16'h0);

    // 3: write-record then dummy frame
    v0 = valid_cnt;
    send_frame({6'd4, 10'h008, 16'h001D}, 32, rd, bm);
    check("t3a_valid_cnt", 32'(valid_cnt - v0), 32'd1);
    check_cmd("t3a", 6'd4, 10'h008, 16'h001D);
    v0 = valid_cnt;
    send_frame(32'h0, 32, rd, bm);
    check("t3b_valid_cnt", 32'(valid_cnt - v0), 32'd1);
    check_cmd("t3b", 6'd0, 10'd0, 16'd0);

    // 4: short and long frames must not disturb held fields
    send_frame({6'd7, 10'h155, 16'hBEEF}, 32, rd, bm);
    check_cmd("t4_pre", 6'd7, 10'h155, 16'hBEEF);
    v0 = valid_cnt; e0 = err_cnt;
    send_frame({6'd19, 10'h3C3, 16'h1234}, 20, rd, bm);
    check("t4_short_err",   32'(err_cnt - e0),   32'd1);
    check("t4_short_valid", 32'(valid_cnt - v0), 32'd0);
    v0 = valid_cnt; e0 = err_cnt;
    send_frame({6'd4, 10'h2AA, 16'h5678}, 33, rd, bm);
    check("t4_long_err",    32'(err_cnt - e0),   32'd1);
    check("t4_long_valid",  32'(valid_cnt - v0), 32'd0);
    check_cmd("t4_post", 6'd7, 10'h155, 16'hBEEF);

    // 5: reset in the middle of a frame
    v0 = valid_cnt; e0 = err_cnt;
    cs_n = 1'b0;
    #200;
    for (int i = 0; i < 12; i++) begin
      sck = 1'b0; mosi = 1'($urandom_range(1)); #100; sck = 1'b1; #100;
    end
    rst = 1'b1;
    #100;
    check("t5_rst_miso",  32'(miso),      32'd0);
    check("t5_rst_busy",  32'(busy),      32'd0);
    check("t5_rst_valid", 32'(cmd_valid), 32'd0);
    check("t5_rst_err",   32'(frame_err), 32'd0);
    check_cmd("t5_rst", 6'd0, 10'd0, 16'd0);
    rst = 1'b0;
    #200;
    for (int i = 0; i < 4; i++) begin
      sck = 1'b0; mosi = 1'b1; #100; sck = 1'b1; #100;
    end
    cs_n = 1'b1;
    #400;
    check("t5_no_valid", 32'(valid_cnt - v0), 32'd0);
    check("t5_no_err",   32'(err_cnt - e0),   32'd0);
    rsp_data = 32'h0F0F_55AA;
    v0 = valid_cnt;
    send_frame({6'd19, 10'h3FF, 16'h8001}, 32, rd, bm);
    check("t5_miso_word", rd, 32'h0F0F_55AA);
    check("t5_valid_cnt", 32'(valid_cnt - v0), 32'd1);
    check_cmd("t5_next", 6'd19, 10'h3FF, 16'h8001);

    // 6: sck activity with cs_n high is ignored
    v0 = valid_cnt; e0 = err_cnt; m0 = miso_hi_cnt; b0 = busy_hi_cnt;
    for (int i = 0; i < 10; i++) begin
      sck = 1'b0; mosi = 1'($urandom_range(1)); #100; sck = 1'b1; #100;
    end
    #300;
    check("t6_valid",   32'(valid_cnt - v0),   32'd0);
    check("t6_err",     32'(err_cnt - e0),     32'd0);
    check("t6_miso_hi", 32'(miso_hi_cnt - m0), 32'd0);
    check("t6_busy_hi", 32'(busy_hi_cnt - b0), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
